// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions for RisKy1 blocks.
package functions_pkg;

  // Number of bits needed to hold the unsigned value 'value' (at least 1).
  function automatic int bit_size(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/skid_fifo_if.sv
// Valid/ready handshake bundle for both sides of skid_fifo.
// slave: the FIFO itself; master: the surrounding pipeline stages.
interface skid_fifo_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid_in;
  logic [WIDTH-1:0] wr_data_in;
  logic             wr_ready_out;
  logic             rd_valid_out;
  logic [WIDTH-1:0] rd_data_out;
  logic             rd_ready_in;

  modport slave (
    input  wr_valid_in,
    input  wr_data_in,
    output wr_ready_out,
    output rd_valid_out,
    output rd_data_out,
    input  rd_ready_in
  );

  modport master (
    output wr_valid_in,
    output wr_data_in,
    input  wr_ready_out,
    input  rd_valid_out,
    input  rd_data_out,
    output rd_ready_in
  );
endinterface

// File: rtl/skid_fifo_chk.sv
// Simulation-only protocol checker for the skid_fifo write side: a
// write offer that is not accepted must be held with stable data until
// it is accepted, unless the pipeline is flushed.
module skid_fifo_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk_in,
  input logic             reset_in,
  input logic             flush_in,
  input logic             wr_valid_in,
  input logic             wr_ready_out,
  input logic [WIDTH-1:0] wr_data_in
);

  // Upstream must not withdraw or change a pending write offer.
  wr_hold_stable : assert property (
    @(posedge clk_in) disable iff (reset_in)
    (wr_valid_in && !wr_ready_out && !flush_in) |=> (wr_valid_in && $stable(wr_data_in))
  ) else $error("skid_fifo_chk: pending write offer dropped or changed");

endmodule

// File: rtl/skid_fifo_wrap_ptr.sv
// Registered circular pointer over 0..DEPTH-1 with explicit wrap, so
// non-power-of-2 depths work without relying on binary overflow.
module wrap_ptr
  import functions_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          clr,
  input  logic                          inc,
  output logic [bit_size(DEPTH-1)-1:0]  ptr
);

  localparam int PTR_W = bit_size(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register: clear wins over increment, wrap from LAST to zero.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/skid_fifo.sv
// skid_fifo: synchronous first-word-fall-through FIFO with valid/ready
// on both sides. Upstream is stalled only when the queue is full; the
// ready output never depends combinationally on the downstream ready.
// Optional build macro SKID_FIFO_HWM_EN adds hwm_out, the maximum
// occupancy seen since reset (not cleared by flush).
module skid_fifo
  import functions_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       flush_in,
  skid_fifo_if.slave                 bus,
  output logic [bit_size(DEPTH)-1:0] count_out,
  output logic                       full_out,
  output logic                       empty_out
`ifdef SKID_FIFO_HWM_EN
  ,output logic [bit_size(DEPTH)-1:0] hwm_out
`endif
);

  localparam int PTR_W = bit_size(DEPTH - 1);
  localparam int CNT_W = bit_size(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign wr_fire = bus.wr_valid_in && !full;
  assign rd_fire = bus.rd_ready_in && !empty;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clr      (flush_in),
    .inc      (wr_fire),
    .ptr      (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clr      (flush_in),
    .inc      (rd_fire),
    .ptr      (rd_ptr)
  );

  // Occupancy: flush empties; simultaneous read and write leaves it unchanged.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      count <= '0;
    end else if (flush_in) begin
      count <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write coinciding with a flush is dropped.
  always_ff @(posedge clk_in) begin
    if (wr_fire && !flush_in) begin
      mem[wr_ptr] <= bus.wr_data_in;
    end
  end

  // Status and handshake outputs derived from registered state only.
  always_comb begin
    count_out        = count;
    full_out         = full;
    empty_out        = empty;
    bus.wr_ready_out = !full;
    bus.rd_valid_out = !empty;
    if (empty) begin
      bus.rd_data_out = '0;
    end else begin
      bus.rd_data_out = mem[rd_ptr];
    end
  end

`ifdef SKID_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm;

  // High-water mark: follows count upward, cleared only by reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hwm <= '0;
    end else if (count > hwm) begin
      hwm <= count;
    end
  end

  assign hwm_out = hwm;
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo: a DEPTH=4 and a DEPTH=3 instance,
// each compared every cycle against a queue-based reference model.
module tb_skid_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       flush4, flush3;
  logic [2:0] count4;
  logic [1:0] count3;
  logic       full4, empty4, full3, empty3;
`ifdef SKID_FIFO_HWM_EN
  logic [2:0] hwm4;
  logic [1:0] hwm3;
`endif

  skid_fifo_if #(.WIDTH(32)) bus4 ();
  skid_fifo_if #(.WIDTH(32)) bus3 ();

  skid_fifo #(.DEPTH(4), .WIDTH(32)) dut4 (
    .clk_in(clk), .reset_in(rst), .flush_in(flush4), .bus(bus4.slave),
    .count_out(count4), .full_out(full4), .empty_out(empty4)
`ifdef SKID_FIFO_HWM_EN
    , .hwm_out(hwm4)
`endif
  );

  skid_fifo #(.DEPTH(3), .WIDTH(32)) dut3 (
    .clk_in(clk), .reset_in(rst), .flush_in(flush3), .bus(bus3.slave),
    .count_out(count3), .full_out(full3), .empty_out(empty3)
`ifdef SKID_FIFO_HWM_EN
    , .hwm_out(hwm3)
`endif
  );

  skid_fifo_chk #(.WIDTH(32)) pchk4 (
    .clk_in(clk), .reset_in(rst), .flush_in(flush4),
    .wr_valid_in(bus4.wr_valid_in), .wr_ready_out(bus4.wr_ready_out),
    .wr_data_in(bus4.wr_data_in)
  );

  skid_fifo_chk #(.WIDTH(32)) pchk3 (
    .clk_in(clk), .reset_in(rst), .flush_in(flush3),
    .wr_valid_in(bus3.wr_valid_in), .wr_ready_out(bus3.wr_ready_out),
    .wr_data_in(bus3.wr_data_in)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queue contents plus high-water mark.
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int          hwm4_m;
  int          hwm3_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check4();
    logic [31:0] head;
    head = (q4.size() > 0) ? q4[0] : 32'h0;
    chk("d4_count",    32'(count4),            32'(q4.size()));
    chk("d4_full",     32'(full4),             32'(q4.size() == 4));
    chk("d4_empty",    32'(empty4),            32'(q4.size() == 0));
    chk("d4_wr_ready", 32'(bus4.wr_ready_out), 32'(q4.size() < 4));
    chk("d4_rd_valid", 32'(bus4.rd_valid_out), 32'(q4.size() > 0));
    chk("d4_rd_data",  bus4.rd_data_out,       head);
`ifdef SKID_FIFO_HWM_EN
    chk("d4_hwm",      32'(hwm4),              32'(hwm4_m));
`endif
  endtask

  task automatic check3();
    logic [31:0] head;
    head = (q3.size() > 0) ? q3[0] : 32'h0;
    chk("d3_count",    32'(count3),            32'(q3.size()));
    chk("d3_full",     32'(full3),             32'(q3.size() == 3));
    chk("d3_empty",    32'(empty3),            32'(q3.size() == 0));
    chk("d3_wr_ready", 32'(bus3.wr_ready_out), 32'(q3.size() < 3));
    chk("d3_rd_valid", 32'(bus3.rd_valid_out), 32'(q3.size() > 0));
    chk("d3_rd_data",  bus3.rd_data_out,       head);
`ifdef SKID_FIFO_HWM_EN
    chk("d3_hwm",      32'(hwm3),              32'(hwm3_m));
`endif
  endtask

  // One cycle on the DEPTH=4 instance: drive, check, clock, update model.
  task automatic step4(input logic wv, input logic [31:0] wd, input logic rr,
                       input logic fl, output logic wfire);
    logic rfire;
    bus4.wr_valid_in = wv;
    bus4.wr_data_in  = wd;
    bus4.rd_ready_in = rr;
    flush4           = fl;
    #1;
    check4();
    wfire = wv && (q4.size() < 4);
    rfire = rr && (q4.size() > 0);
    if (q4.size() > hwm4_m) hwm4_m = q4.size();
    @(posedge clk);
    #1;
    if (fl) begin
      q4.delete();
    end else begin
      if (rfire) void'(q4.pop_front());
      if (wfire) q4.push_back(wd);
    end
  endtask

  // One cycle on the DEPTH=3 instance.
  task automatic step3(input logic wv, input logic [31:0] wd, input logic rr,
                       input logic fl, output logic wfire);
    logic rfire;
    bus3.wr_valid_in = wv;
    bus3.wr_data_in  = wd;
    bus3.rd_ready_in = rr;
    flush3           = fl;
    #1;
    check3();
    wfire = wv && (q3.size() < 3);
    rfire = rr && (q3.size() > 0);
    if (q3.size() > hwm3_m) hwm3_m = q3.size();
    @(posedge clk);
    #1;
    if (fl) begin
      q3.delete();
    end else begin
      if (rfire) void'(q3.pop_front());
      if (wfire) q3.push_back(wd);
    end
  endtask

  initial begin
    logic        w;
    logic        pend;
    logic [31:0] pend_d;
    logic        wv;
    logic [31:0] wd;
    logic        fl;

    rst = 1'b1;
    flush4 = 1'b0; flush3 = 1'b0;
    bus4.wr_valid_in = 1'b0; bus4.wr_data_in = 32'h0; bus4.rd_ready_in = 1'b0;
    bus3.wr_valid_in = 1'b0; bus3.wr_data_in = 32'h0; bus3.rd_ready_in = 1'b0;
    hwm4_m = 0; hwm3_m = 0;

    // Reset state.
    #2;
    check4();
    check3();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill DEPTH=4 without reading; a 5th offer stalls while full.
    step4(1'b1, 32'h11, 1'b0, 1'b0, w);
    step4(1'b1, 32'h22, 1'b0, 1'b0, w);
    step4(1'b1, 32'h33, 1'b0, 1'b0, w);
    step4(1'b1, 32'h44, 1'b0, 1'b0, w);
    step4(1'b1, 32'h55, 1'b0, 1'b0, w);
    chk("d4_fifth_rejected", 32'(w), 32'h0);
    // Read while full: slot frees next cycle, not this one.
    step4(1'b1, 32'h55, 1'b1, 1'b0, w);
    chk("d4_full_read_no_pass", 32'(w), 32'h0);
    step4(1'b1, 32'h55, 1'b1, 1'b0, w);
    repeat (4) step4(1'b0, 32'h0, 1'b1, 1'b0, w);

    // Flush with 2 stored and a simultaneous write of 0xAA.
    step4(1'b1, 32'hA1, 1'b0, 1'b0, w);
    step4(1'b1, 32'hA2, 1'b0, 1'b0, w);
    step4(1'b1, 32'hAA, 1'b1, 1'b1, w);
    step4(1'b0, 32'h0, 1'b1, 1'b0, w);
    step4(1'b1, 32'h5A, 1'b0, 1'b0, w);
    step4(1'b0, 32'h0, 1'b1, 1'b0, w);
    step4(1'b0, 32'h0, 1'b1, 1'b0, w);

    // Randomized traffic obeying the hold-until-accepted rule.
    pend = 1'b0;
    pend_d = 32'h0;
    for (int i = 0; i < 300; i++) begin
      if (pend) begin
        wv = 1'b1;
        wd = pend_d;
      end else begin
        wv = 1'($urandom_range(0, 1));
        wd = $urandom;
      end
      fl = ($urandom_range(0, 19) == 0);
      step4(wv, wd, ($urandom_range(0, 3) != 0), fl, w);
      pend   = wv && !w && !fl;
      pend_d = wd;
    end
    step4(pend, pend_d, 1'b0, 1'b1, w);
    step4(1'b0, 32'h0, 1'b0, 1'b0, w);

    // DEPTH=3 wrap: one prefill, then write+read every cycle.
    step3(1'b1, 32'h100, 1'b0, 1'b0, w);
    for (int i = 0; i < 10; i++) begin
      step3(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, w);
    end
    step3(1'b0, 32'h0, 1'b1, 1'b0, w);
    step3(1'b0, 32'h0, 1'b0, 1'b0, w);

    // Reset between clock edges with 3 entries stored.
    step4(1'b1, 32'h61, 1'b0, 1'b0, w);
    step4(1'b1, 32'h62, 1'b0, 1'b0, w);
    step4(1'b1, 32'h63, 1'b0, 1'b0, w);
    bus4.wr_valid_in = 1'b0;
    bus4.rd_ready_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q4.delete(); q3.delete();
    hwm4_m = 0; hwm3_m = 0;
    check4();
    check3();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // High-water mark: fill to 3, drain, flush; mark stays at 3.
    for (int i = 0; i < 3; i++) step4(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0, w);
    for (int i = 0; i < 3; i++) step4(1'b0, 32'h0, 1'b1, 1'b0, w);
    step4(1'b0, 32'h0, 1'b0, 1'b1, w);
    step4(1'b0, 32'h0, 1'b0, 1'b0, w);
    step4(1'b0, 32'h0, 1'b0, 1'b0, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
